mag_cook_sequencer: RTL and testbench
=====================================

Name: mag_cook_sequencer

Overview:
Cook-cycle controller for the microwave magnetron. It takes operator button events, the door interlock, a loaded cook time and a power level, and runs the countdown timer. It drives the magnetron enable with a time-sliced duty cycle and signals completion. It sits above the magnetron on/off logic and replaces the free-running SR latch with a clocked, sequenced controller.

Parameters:
TICKS_PER_SEC, 50000000, clock cycles per 1-second tick (bench uses 4)
TIME_W, 13, width of the seconds counter (max 8191 s)
POWER_SLOTS, 10, seconds per power duty window

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
startn  input  1  start button, active low, pre-debounced, synchronous to clk
stopn  input  1  stop/pause button, active low, pre-debounced
clearn  input  1  clear/cancel button, active low, pre-debounced
door_closed  input  1  door interlock, 1 = closed
load  input  1  one-cycle strobe: capture load_sec
load_sec  input  TIME_W  cook time in seconds
power  input  4  power level 0..10; values >10 are treated as 10
mag_on  output  1  magnetron enable
timer_done  output  1  high while in DONE
remaining_sec  output  TIME_W  seconds left
state  output  3  IDLE=0, READY=1, COOKING=2, PAUSED=3, DONE=4

Behaviour:
- Buttons: falling-edge detected against a registered previous value (prev regs reset to 1). Only edges act; held-low buttons act once.
- Reset (synchronous, active-high): state=IDLE, remaining_sec=0, prescaler=0, slot=0, mag_on=0, timer_done=0.
- Prescaler: counts 0..TICKS_PER_SEC-1 only in COOKING. The tick is the cycle the prescaler wraps. It holds its value in PAUSED. It is cleared on every READY->COOKING transition.
- Each tick: remaining_sec decrements by 1; slot counts 0..POWER_SLOTS-1 and wraps.
- Duty: mag_en_r is a register = (next state == COOKING) && (slot_next < power_eff).
- Output: mag_on = mag_en_r & door_closed. This is a combinational door gate, so the door opening drops mag_on in the same cycle.
- power_eff = min(power, 10). With power 0 the timer runs and mag_on stays 0. power is sampled live each cycle.
- Event priority within a cycle: clear > stop > door open > tick > start > load.
- IDLE:
  - load with load_sec != 0 -> READY, remaining_sec = load_sec.
  - load with 0 is ignored.
- READY:
  - start edge with door_closed -> COOKING; slot=0, prescaler=0.
  - start edge with door open is ignored.
  - load reloads remaining_sec.
  - clear edge -> IDLE, remaining_sec=0.
- COOKING:
  - clear -> IDLE, remaining_sec=0.
  - stop -> PAUSED.
  - door_closed=0 -> PAUSED; a tick in that same cycle is discarded and the prescaler holds.
  - tick with remaining_sec==1 -> DONE, remaining_sec=0, mag_en_r=0.
  - load is ignored.
- PAUSED:
  - start edge with door_closed -> COOKING; prescaler and slot resume, not cleared.
  - stop or clear edge -> IDLE, remaining_sec=0 (second-press cancel).
  - Closing the door alone does not resume.
  - load is ignored.
- DONE:
  - timer_done=1.
  - clear edge or door_closed falling -> IDLE.
  - load is accepted -> READY (re-arm).
- remaining_sec never underflows. COOKING is only entered with remaining_sec >= 1.
- Outputs other than mag_on are registered.

Test Plan:
1. TICKS=4, power 10, load 3, door closed, start edge at cycle 0 -> state=COOKING at cycle 1; mag_on=1 for 12 cycles; remaining_sec 3,2,1,0 at 4-cycle steps; state=DONE and timer_done=1 after the 12th cycle; mag_on=0.
2. TICKS=4, power 3, load 10, start -> mag_on high for the first 12 cycles, low for the next 28; DONE after 40 cycles.
3. Door opens 6 cycles into cooking -> mag_on=0 in the same cycle; state=PAUSED; remaining_sec frozen. Door closed without start -> stays PAUSED. Start -> resumes; total powered cycles still equals loaded time × TICKS.
4. Stop edge during COOKING -> PAUSED, remaining held. Second stop edge -> IDLE, remaining_sec=0, mag_on=0.
5. Boundary cases:
   - start edge in READY with door open -> stays READY.
   - clear and start edges in the same cycle during COOKING -> IDLE.
   - load with load_sec=0 in IDLE -> stays IDLE.
   - startn held low for 20 cycles -> a single start.
6. reset asserted mid-COOKING with mag_on=1 -> next cycle state=IDLE, mag_on=0, remaining_sec=0, timer_done=0. After release, a start edge alone does nothing.

Source files
------------

// File: rtl/mag_cook_sequencer.sv
// Microwave cook-cycle controller: button edge detection, countdown timer,
// time-sliced magnetron duty and door-gated enable.
module mag_cook_sequencer #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned TIME_W        = 13,
  parameter int unsigned POWER_SLOTS   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              door_closed,
  input  logic              load,
  input  logic [TIME_W-1:0] load_sec,
  input  logic [3:0]        power,
  output logic              mag_on,
  output logic              timer_done,
  output logic [TIME_W-1:0] remaining_sec,
  output logic [2:0]        state
);

  localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned SLOT_W  = (POWER_SLOTS > 1) ? $clog2(POWER_SLOTS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(POWER_SLOTS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READY   = 3'd1,
    COOKING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state_q, state_n;
  logic [TIME_W-1:0]   rem_q, rem_n;
  logic [PRESC_W-1:0]  presc_q, presc_n;
  logic [SLOT_W-1:0]   slot_q, slot_n;
  logic                mag_en_q, done_q;
  logic                start_prev, stop_prev, clear_prev, door_prev;
  logic                start_edge, stop_edge, clear_edge, door_fall, load_ok, tick;
  logic [3:0]          power_eff;

  assign start_edge = start_prev & ~startn;
  assign stop_edge  = stop_prev & ~stopn;
  assign clear_edge = clear_prev & ~clearn;
  assign door_fall  = door_prev & ~door_closed;
  assign load_ok    = load && (load_sec != '0);
  assign power_eff  = (power > 4'd10) ? 4'd10 : power;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      presc_q    <= '0;
      slot_q     <= '0;
      mag_en_q   <= 1'b0;
      done_q     <= 1'b0;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
      clear_prev <= 1'b1;
      door_prev  <= 1'b0;
    end else begin
      state_q    <= state_n;
      rem_q      <= rem_n;
      presc_q    <= presc_n;
      slot_q     <= slot_n;
      mag_en_q   <= (state_n == COOKING) && (32'(slot_n) < 32'(power_eff));
      done_q     <= (state_n == DONE);
      start_prev <= startn;
      stop_prev  <= stopn;
      clear_prev <= clearn;
      door_prev  <= door_closed;
    end
  end

  // Branch order within each state encodes clear > stop > door > tick > start > load.
  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    presc_n = presc_q;
    slot_n  = slot_q;
    tick    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!clear_edge && load_ok) begin
          state_n = READY;
          rem_n   = load_sec;
        end
      end
      READY: begin
        if (clear_edge) begin
          state_n = IDLE;
          rem_n   = '0;
        end else if (start_edge && door_closed) begin
          state_n = COOKING;
          presc_n = '0;
          slot_n  = '0;
        end else if (load_ok) begin
          rem_n = load_sec;
        end
      end
      COOKING: begin
        if (clear_edge) begin
          state_n = IDLE;
          rem_n   = '0;
        end else if (stop_edge || !door_closed) begin
          state_n = PAUSED;
        end else begin
          tick    = (presc_q == PRESC_LAST);
          presc_n = tick ? '0 : presc_q + PRESC_W'(1);
          if (tick) begin
            slot_n = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            if (rem_q <= TIME_W'(1)) begin
              state_n = DONE;
              rem_n   = '0;
            end else begin
              rem_n = rem_q - TIME_W'(1);
            end
          end
        end
      end
      PAUSED: begin
        if (clear_edge || stop_edge) begin
          state_n = IDLE;
          rem_n   = '0;
        end else if (start_edge && door_closed) begin
          state_n = COOKING;
        end
      end
      DONE: begin
        if (clear_edge || door_fall) begin
          state_n = IDLE;
          rem_n   = '0;
        end else if (load_ok) begin
          state_n = READY;
          rem_n   = load_sec;
        end
      end
      default: begin
        state_n = IDLE;
        rem_n   = '0;
      end
    endcase
  end

  // Door gate is combinational so opening the door cuts power immediately.
  always_comb begin
    mag_on        = mag_en_q & door_closed;
    timer_done    = done_q;
    remaining_sec = rem_q;
    state         = state_q;
  end

endmodule

// File: tb/tb_mag_cook_sequencer.sv
// Self-checking bench for mag_cook_sequencer: vector table, directed corner
// sequences and randomized traffic checked against a seconds-level model.
module tb_mag_cook_sequencer;

  localparam int TICKS = 4;
  localparam int TW    = 13;
  localparam int SLOTS = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
  logic          door_closed = 1'b1, load = 1'b0;
  logic [TW-1:0] load_sec = '0;
  logic [3:0]    power = 4'd10;
  logic          mag_on, timer_done;
  logic [TW-1:0] remaining_sec;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  int pre_on = 0;

  mag_cook_sequencer #(.TICKS_PER_SEC(TICKS), .TIME_W(TW), .POWER_SLOTS(SLOTS)) dut (
    .clk(clk), .reset(reset), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .load(load), .load_sec(load_sec), .power(power),
    .mag_on(mag_on), .timer_done(timer_done), .remaining_sec(remaining_sec),
    .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: a state number, seconds left, cycles into the current
  // second and whole seconds cooked in this session (duty slot = secs mod SLOTS).
  int m_state, m_rem, m_sub, m_secs;
  bit m_en, m_done, m_pstart, m_pstop, m_pclear, m_pdoor;

  task automatic model_step();
    bit se, pe, ce, df, lok;
    int pw;
    if (reset) begin
      m_state = 0; m_rem = 0; m_sub = 0; m_secs = 0; m_en = 0; m_done = 0;
      m_pstart = 1; m_pstop = 1; m_pclear = 1; m_pdoor = 0;
      return;
    end
    se  = m_pstart && !startn;
    pe  = m_pstop && !stopn;
    ce  = m_pclear && !clearn;
    df  = m_pdoor && !door_closed;
    lok = load && (load_sec != 0);
    case (m_state)
      0: if (!ce && lok) begin m_state = 1; m_rem = int'(load_sec); end
      1: begin
        if (ce) begin m_state = 0; m_rem = 0; end
        else if (se && door_closed) begin m_state = 2; m_sub = 0; m_secs = 0; end
        else if (lok) m_rem = int'(load_sec);
      end
      2: begin
        if (ce) begin m_state = 0; m_rem = 0; end
        else if (pe || !door_closed) m_state = 3;
        else begin
          m_sub++;
          if (m_sub == TICKS) begin
            m_sub = 0; m_secs++; m_rem--;
            if (m_rem == 0) m_state = 4;
          end
        end
      end
      3: begin
        if (ce || pe) begin m_state = 0; m_rem = 0; end
        else if (se && door_closed) m_state = 2;
      end
      default: begin
        if (ce || df) begin m_state = 0; m_rem = 0; end
        else if (lok) begin m_state = 1; m_rem = int'(load_sec); end
      end
    endcase
    pw = (int'(power) > 10) ? 10 : int'(power);
    m_en = (m_state == 2) && ((m_secs % SLOTS) < pw);
    m_done = (m_state == 4);
    m_pstart = startn; m_pstop = stopn; m_pclear = clearn; m_pdoor = door_closed;
  endtask

  // One clock: count powered cycles, advance the model, sample after the edge.
  task automatic step();
    #1;
    if (mag_on) pre_on++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string name);
    checks++;
    if (int'(state) != m_state || int'(remaining_sec) != m_rem ||
        mag_on !== (m_en & door_closed) || timer_done !== m_done) begin
      errors++;
      $display("FAIL %s: got state=%0d rem=%0d mag_on=%0b done=%0b, want state=%0d rem=%0d mag_on=%0b done=%0b",
               name, state, remaining_sec, mag_on, timer_done, m_state, m_rem,
               m_en & door_closed, m_done);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    startn = 1; stopn = 1; clearn = 1; door_closed = 1; load = 0; load_sec = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    check_model("reset_model");
    check_val("reset_state", int'(state), 0);
    check_val("reset_rem", int'(remaining_sec), 0);
    check_val("reset_mag", int'(mag_on), 0);
    check_val("reset_done", int'(timer_done), 0);
    reset = 0;
  endtask

  // Load, start and run to DONE; reports cooking cycles and powered cycles.
  task automatic cook_run(input int secs, input int pw, input string tag,
                          output int cycles, output int on);
    power = 4'(pw);
    load = 1; load_sec = TW'(secs);
    step(); check_model({tag, "_load"});
    load = 0; startn = 0;
    step(); check_model({tag, "_start"});
    startn = 1;
    pre_on = 0; cycles = 0;
    while (state != 3'd4 && cycles < 500) begin
      step(); cycles++;
      check_model({tag, "_run"});
    end
    on = pre_on;
  endtask

  typedef struct {
    logic startn, stopn, clearn, door, load;
    int sec, pw, st, rem;
    logic mag, done;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic p, input logic c, input logic d,
                              input logic l, input int sec, input int pw, input int st,
                              input int rem, input logic mag, input logic done);
    vec_t v;
    v.startn = s; v.stopn = p; v.clearn = c; v.door = d; v.load = l;
    v.sec = sec; v.pw = pw; v.st = st; v.rem = rem; v.mag = mag; v.done = done;
    return v;
  endfunction

  vec_t vecs[18];

  initial begin
    int cyc, on, rem_hold;

    // startn stopn clearn door load sec pw | state rem mag done
    vecs[0]  = mk(1,1,1,1,1,0,10, 0,0,0,0);  // load 0 ignored
    vecs[1]  = mk(1,1,1,1,1,2,10, 1,2,0,0);
    vecs[2]  = mk(0,1,1,0,0,0,10, 1,2,0,0);  // start with door open
    vecs[3]  = mk(1,1,1,1,0,0,10, 1,2,0,0);
    vecs[4]  = mk(0,1,1,1,0,0,10, 2,2,1,0);
    vecs[5]  = mk(0,1,1,1,0,0,10, 2,2,1,0);  // held start
    vecs[6]  = mk(1,1,1,1,0,0,10, 2,2,1,0);
    vecs[7]  = mk(1,1,1,1,1,7,10, 2,2,1,0);  // load ignored while cooking
    vecs[8]  = mk(1,1,1,1,0,0,10, 2,1,1,0);  // first tick
    vecs[9]  = mk(1,1,1,1,0,0,10, 2,1,1,0);
    vecs[10] = mk(1,1,1,1,0,0,10, 2,1,1,0);
    vecs[11] = mk(1,1,1,1,0,0,10, 2,1,1,0);
    vecs[12] = mk(1,1,1,1,0,0,10, 4,0,0,1);  // last tick -> DONE
    vecs[13] = mk(1,1,1,1,1,1,10, 1,1,0,0);  // re-arm from DONE
    vecs[14] = mk(0,1,1,1,0,0,2,  2,1,1,0);
    vecs[15] = mk(1,1,1,1,0,0,2,  2,1,1,0);
    vecs[16] = mk(0,1,0,1,0,0,2,  0,0,0,0);  // clear beats start
    vecs[17] = mk(1,1,1,1,1,0,12, 0,0,0,0);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      startn = vecs[i].startn; stopn = vecs[i].stopn; clearn = vecs[i].clearn;
      door_closed = vecs[i].door; load = vecs[i].load;
      load_sec = TW'(vecs[i].sec); power = 4'(vecs[i].pw);
      step();
      checks++;
      if (int'(state) != vecs[i].st || int'(remaining_sec) != vecs[i].rem ||
          mag_on !== vecs[i].mag || timer_done !== vecs[i].done) begin
        errors++;
        $display("FAIL vec%0d: got state=%0d rem=%0d mag_on=%0b done=%0b, want state=%0d rem=%0d mag_on=%0b done=%0b",
                 i, state, remaining_sec, mag_on, timer_done,
                 vecs[i].st, vecs[i].rem, vecs[i].mag, vecs[i].done);
      end
    end

    // Full power, 3 s
    do_reset();
    cook_run(3, 10, "p10", cyc, on);
    check_val("p10_cycles", cyc, 12);
    check_val("p10_on", on, 12);
    check_val("p10_done", int'(timer_done), 1);
    check_val("p10_mag_off", int'(mag_on), 0);
    door_closed = 0; step(); check_model("done_door_fall");
    check_val("done_door_idle", int'(state), 0);

    // Power 3, 10 s: 3 powered seconds then 7 off
    do_reset();
    cook_run(10, 3, "p3", cyc, on);
    check_val("p3_cycles", cyc, 40);
    check_val("p3_on", on, 12);

    // Door opens mid-cook
    do_reset();
    power = 4'd10; load = 1; load_sec = TW'(3); step();
    load = 0; startn = 0; pre_on = 0; step(); startn = 1;
    for (int i = 0; i < 5; i++) begin step(); check_model("door_pre"); end
    check_val("door_mag_before", int'(mag_on), 1);
    door_closed = 0; #1;
    check_val("door_gate_same_cycle", int'(mag_on), 0);
    step(); check_model("door_pause");
    check_val("door_paused", int'(state), 3);
    rem_hold = int'(remaining_sec);
    for (int i = 0; i < 5; i++) step();
    check_val("door_rem_frozen", int'(remaining_sec), rem_hold);
    door_closed = 1;
    for (int i = 0; i < 3; i++) step();
    check_val("door_close_no_resume", int'(state), 3);
    startn = 0; step(); check_model("door_resume"); startn = 1;
    cyc = 0;
    while (state != 3'd4 && cyc < 200) begin step(); cyc++; check_model("door_run"); end
    check_val("door_total_on", pre_on, 12);

    // Stop then second stop cancels
    do_reset();
    load = 1; load_sec = TW'(5); step();
    load = 0; startn = 0; step(); startn = 1;
    for (int i = 0; i < 3; i++) step();
    stopn = 0; step(); check_model("stop1");
    stopn = 1;
    for (int i = 0; i < 4; i++) step();
    check_val("stop_paused", int'(state), 3);
    check_val("stop_rem_held", int'(remaining_sec), 5);
    stopn = 0; step(); check_model("stop2"); stopn = 1;
    check_val("stop2_idle", int'(state), 0);
    check_val("stop2_rem", int'(remaining_sec), 0);

    // Held start: only one edge, taken while door open, so nothing happens
    do_reset();
    load = 1; load_sec = TW'(2); step(); load = 0;
    door_closed = 0; startn = 0;
    for (int i = 0; i < 10; i++) step();
    door_closed = 1;
    for (int i = 0; i < 10; i++) begin step(); check_model("held_start"); end
    check_val("held_start_ready", int'(state), 1);
    startn = 1; step(); startn = 0; step(); check_model("fresh_start");
    check_val("fresh_start_cook", int'(state), 2);

    // Reset mid-cook, then lone start does nothing
    startn = 1;
    for (int i = 0; i < 2; i++) step();
    check_val("rst_mag_before", int'(mag_on), 1);
    do_reset();
    step(); startn = 0; step(); check_model("rst_start_alone");
    check_val("rst_start_idle", int'(state), 0);

    // Randomized traffic against the model
    idle_inputs();
    for (int i = 0; i < 4000; i++) begin
      reset  = ($urandom_range(0, 299) == 0);
      startn = ($urandom_range(0, 9) < 2) ? 1'b0 : 1'b1;
      stopn  = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
      clearn = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 24) == 0) door_closed = ~door_closed;
      load   = ($urandom_range(0, 14) == 0);
      load_sec = TW'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) power = 4'($urandom_range(0, 15));
      step();
      check_model("random");
    end
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
